// File: rtl/up_pkg.sv
// Shared definitions for the up_core memory-map initiators (loader and dump).
// Holds the dump FSM encoding, memory geometry and the control-slot address.
package up_pkg;

  localparam int         MEM_DEPTH = 256;
  localparam int         DATA_W    = 8;
  localparam int         ADDR_W    = 9;
  localparam logic [8:0] CTRL_ADDR = 9'd256;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

  // A zero length encodes a full-memory sweep.
  function automatic logic [8:0] byte_count(input logic [7:0] len);
    if (len == 8'd0) begin
      return 9'(MEM_DEPTH);
    end else begin
      return {1'b0, len};
    end
  endfunction

endpackage

// File: rtl/up_mem_dump.sv
// Read-side initiator for the up_core memory-map port: sweeps a byte window,
// streams it on a valid/ready interface and keeps a running 8-bit checksum.
module up_mem_dump
  import up_pkg::*;
#(
  parameter int         READ_LAT  = 1,
  parameter logic [8:0] PARK_ADDR = CTRL_ADDR
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [7:0] length,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum,
  output logic       mem_map_load,
  output logic [8:0] mem_map_address,
  input  logic [7:0] mem_map_out,
  output logic [7:0] dump_data,
  output logic       dump_valid,
  input  logic       dump_ready
);

  localparam logic [1:0] WAIT_LOAD = 2'(READ_LAT);

  dump_state_e state_r, state_next_s;
  logic [7:0]  addr_r, addr_next_s;
  logic [8:0]  remaining_r, remaining_next_s;
  logic [1:0]  wait_r, wait_next_s;
  logic [7:0]  checksum_r, checksum_next_s;
  logic [8:0]  mem_addr_r, mem_addr_next_s;
  logic [7:0]  dump_data_r, dump_data_next_s;
  logic        dump_valid_r, dump_valid_next_s;
  logic        busy_r, busy_next_s;
  logic        done_r, done_next_s;
  logic        xfer_s;

  assign xfer_s = dump_valid_r & dump_ready;

  // FSM state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_next_s      = state_r;
    addr_next_s       = addr_r;
    remaining_next_s  = remaining_r;
    wait_next_s       = wait_r;
    checksum_next_s   = checksum_r;
    mem_addr_next_s   = mem_addr_r;
    dump_data_next_s  = dump_data_r;
    dump_valid_next_s = dump_valid_r;
    busy_next_s       = busy_r;
    done_next_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          addr_next_s      = start_addr;
          remaining_next_s = byte_count(length);
          checksum_next_s  = 8'd0;
          mem_addr_next_s  = {1'b0, start_addr};
          busy_next_s      = 1'b1;
          state_next_s     = ST_ADDR;
        end else begin
          mem_addr_next_s  = PARK_ADDR;
          state_next_s     = ST_IDLE;
        end
      end
      ST_ADDR: begin
        wait_next_s  = WAIT_LOAD;
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        wait_next_s = wait_r - 2'd1;
        // The counter reaching zero on this decrement means the read data is valid now
        if (wait_r == 2'd1) begin
          dump_data_next_s  = mem_map_out;
          dump_valid_next_s = 1'b1;
          state_next_s      = ST_EMIT;
        end else begin
          state_next_s      = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (xfer_s) begin
          checksum_next_s   = checksum_r + dump_data_r;
          addr_next_s       = addr_r + 8'd1;
          remaining_next_s  = remaining_r - 9'd1;
          dump_valid_next_s = 1'b0;
          if (remaining_r == 9'd1) begin
            mem_addr_next_s = PARK_ADDR;
            done_next_s     = 1'b1;
            state_next_s    = ST_DONE;
          end else begin
            mem_addr_next_s = {1'b0, addr_r + 8'd1};
            state_next_s    = ST_ADDR;
          end
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        mem_addr_next_s = PARK_ADDR;
        busy_next_s     = 1'b0;
        state_next_s    = ST_IDLE;
      end
      default: begin
        mem_addr_next_s   = PARK_ADDR;
        dump_valid_next_s = 1'b0;
        busy_next_s       = 1'b0;
        state_next_s      = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      addr_r       <= 8'd0;
      remaining_r  <= 9'd0;
      wait_r       <= 2'd0;
      checksum_r   <= 8'd0;
      mem_addr_r   <= PARK_ADDR;
      dump_data_r  <= 8'd0;
      dump_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      addr_r       <= addr_next_s;
      remaining_r  <= remaining_next_s;
      wait_r       <= wait_next_s;
      checksum_r   <= checksum_next_s;
      mem_addr_r   <= mem_addr_next_s;
      dump_data_r  <= dump_data_next_s;
      dump_valid_r <= dump_valid_next_s;
      busy_r       <= busy_next_s;
      done_r       <= done_next_s;
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign checksum        = checksum_r;
  assign mem_map_load    = 1'b0;
  assign mem_map_address = mem_addr_r;
  assign dump_data       = dump_data_r;
  assign dump_valid      = dump_valid_r;

endmodule

// File: tb/tb_up_mem_dump.sv
// Randomized bench for up_mem_dump: two instances (READ_LAT 1 and 3) share a
// memory model and are checked against an array model of the expected stream.
module tb_up_mem_dump;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic       clk;
  logic       nRst;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] length;
  logic       busy [2];
  logic       done [2];
  logic [7:0] checksum [2];
  logic       mload [2];
  logic [8:0] maddr [2];
  logic [7:0] mout [2];
  logic [7:0] ddata [2];
  logic       dvalid [2];
  logic       rdy [2];

  logic [7:0] mem [256];
  logic [7:0] pipe0;
  logic [7:0] pipe1 [3];

  // reference model of the current dump
  logic [7:0] exp_b [256];
  int         exp_n;
  logic [7:0] exp_sa;
  logic [7:0] exp_sum;
  int         ptr [2];
  int         done_cnt [2];
  int         stall [2];
  int         rmode;

  int nvec;
  int nerr;

  up_mem_dump #(.READ_LAT(LAT0)) dut0 (
    .clk(clk), .nRst(nRst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy[0]), .done(done[0]), .checksum(checksum[0]), .mem_map_load(mload[0]),
    .mem_map_address(maddr[0]), .mem_map_out(mout[0]), .dump_data(ddata[0]),
    .dump_valid(dvalid[0]), .dump_ready(rdy[0])
  );

  up_mem_dump #(.READ_LAT(LAT1)) dut1 (
    .clk(clk), .nRst(nRst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy[1]), .done(done[1]), .checksum(checksum[1]), .mem_map_load(mload[1]),
    .mem_map_address(maddr[1]), .mem_map_out(mout[1]), .dump_data(ddata[1]),
    .dump_valid(dvalid[1]), .dump_ready(rdy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory with READ_LAT clocks of latency from a stable address
  always @(posedge clk) begin
    pipe0    <= mem[maddr[0][7:0]];
    pipe1[0] <= mem[maddr[1][7:0]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign mout[0] = pipe0;
  assign mout[1] = pipe1[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // sink: ready policy per instance, driven just after the rising edge
  initial begin
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        case (rmode)
          1: rdy[g] = 1'($urandom_range(0, 1));
          2: begin
            if (dvalid[g] && ptr[g] == 1 && stall[g] < 10) begin
              rdy[g] = 1'b0;
              stall[g]++;
            end else begin
              rdy[g] = 1'b1;
            end
          end
          default: rdy[g] = 1'b1;
        endcase
      end
    end
  end

  // monitor: stream order, address, hold under backpressure, latency, done
  initial begin
    logic       p_dv [2];
    logic       p_rdy [2];
    logic [7:0] p_data [2];
    logic [8:0] p_addr [2];
    int         lat_cnt [2];
    logic [7:0] ea;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!nRst) begin
          p_dv[g] = 1'b0; p_rdy[g] = 1'b1; p_data[g] = 8'd0;
          p_addr[g] = 9'd256; lat_cnt[g] = 0;
        end else begin
          if (maddr[g] != p_addr[g]) lat_cnt[g] = 0;
          else lat_cnt[g]++;
          if (dvalid[g] && !p_dv[g])
            check_eq($sformatf("latency%0d", g), lat_cnt[g], (g == 0) ? LAT0 + 1 : LAT1 + 1);
          if (p_dv[g] && !p_rdy[g]) begin
            check_eq($sformatf("hold_valid%0d", g), dvalid[g], 1);
            check_eq($sformatf("hold_data%0d", g), ddata[g], p_data[g]);
            check_eq($sformatf("hold_addr%0d", g), maddr[g], p_addr[g]);
          end
          if (busy[g] && !done[g])
            check_eq($sformatf("no_park_mid%0d", g), maddr[g][8], 0);
          if (dvalid[g] && rdy[g]) begin
            if (ptr[g] < exp_n) begin
              ea = exp_sa + 8'(ptr[g]);
              check_eq($sformatf("data%0d[%0d]", g, ptr[g]), ddata[g], exp_b[ptr[g]]);
              check_eq($sformatf("addr%0d[%0d]", g, ptr[g]), maddr[g], {1'b0, ea});
            end else begin
              check_eq($sformatf("extra_byte%0d", g), ptr[g], exp_n - 1);
            end
            ptr[g]++;
          end
          if (done[g]) begin
            done_cnt[g]++;
            check_eq($sformatf("done_after_all%0d", g), ptr[g], exp_n);
          end
          p_dv[g] = dvalid[g]; p_rdy[g] = rdy[g]; p_data[g] = ddata[g]; p_addr[g] = maddr[g];
        end
      end
    end
  end

  task automatic begin_dump(input logic [7:0] sa, input logic [7:0] len, input int mode);
    exp_n   = (len == 8'd0) ? 256 : int'(len);
    exp_sa  = sa;
    exp_sum = 8'd0;
    for (int k = 0; k < exp_n; k++) begin
      exp_b[k] = mem[(int'(sa) + k) % 256];
      exp_sum  = exp_sum + exp_b[k];
    end
    for (int g = 0; g < 2; g++) begin
      ptr[g] = 0; done_cnt[g] = 0; stall[g] = 0;
      check_eq($sformatf("idle_before%0d", g), busy[g], 0);
    end
    rmode = mode;
    @(posedge clk); #1;
    start_addr = sa; length = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int g = 0; g < 2; g++) check_eq($sformatf("busy_after_start%0d", g), busy[g], 1);
  endtask

  task automatic end_dump();
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done_cnt[0] >= 1 && done_cnt[1] >= 1) break;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("done_count%0d", g), done_cnt[g], 1);
      check_eq($sformatf("bytes%0d", g), ptr[g], exp_n);
      check_eq($sformatf("checksum%0d", g), checksum[g], exp_sum);
      check_eq($sformatf("busy_end%0d", g), busy[g], 0);
      check_eq($sformatf("parked%0d", g), maddr[g], 9'd256);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("%s_busy%0d", tag, g), busy[g], 0);
      check_eq($sformatf("%s_done%0d", tag, g), done[g], 0);
      check_eq($sformatf("%s_checksum%0d", tag, g), checksum[g], 0);
      check_eq($sformatf("%s_load%0d", tag, g), mload[g], 0);
      check_eq($sformatf("%s_addr%0d", tag, g), maddr[g], 9'd256);
      check_eq($sformatf("%s_data%0d", tag, g), ddata[g], 0);
      check_eq($sformatf("%s_valid%0d", tag, g), dvalid[g], 0);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; rmode = 0; exp_n = 0; exp_sa = 8'd0; exp_sum = 8'd0;
    for (int g = 0; g < 2; g++) begin ptr[g] = 0; done_cnt[g] = 0; stall[g] = 0; end
    nRst = 1'b0; start = 1'b0; start_addr = 8'd0; length = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // full sweep, identity contents
    begin_dump(8'h00, 8'h00, 0);
    end_dump();

    // wrap past 0xFF, inverted contents
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    begin_dump(8'hFE, 8'h04, 0);
    end_dump();

    // 10-clock stall on the second byte
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    begin_dump(8'($urandom), 8'h03, 2);
    end_dump();
    for (int g = 0; g < 2; g++) check_eq($sformatf("stall_len%0d", g), stall[g], 10);

    // single byte latency probe
    mem[8'h10] = 8'hA5;
    begin_dump(8'h10, 8'h01, 0);
    end_dump();

    // start mid-dump must be ignored
    begin_dump(8'($urandom), 8'h08, 1);
    repeat (5) @(posedge clk);
    #1; start_addr = exp_sa + 8'd77; length = 8'h09; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    end_dump();

    // async reset during byte 5 of 10
    begin_dump(8'($urandom), 8'h0A, 0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ptr[0] == 4 && dvalid[0]) break;
    end
    check_eq("reached_byte5", ptr[0], 4);
    #2; nRst = 1'b0;
    #1; check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    begin_dump(8'($urandom), 8'h06, 1);
    end_dump();

    // random windows under random backpressure
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      begin_dump(8'($urandom), 8'($urandom_range(1, 40)), 1);
      end_dump();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
